bep_frame_encoder: RTL
======================

BEP_FRAME_ENCODER -- requirements
Module: bep_frame_encoder

Interface
REQ-001 Parameter HALF_BIT_CYCLES, default 250: clock cycles per Manchester half-bit; legal range 1..4095.
REQ-002 Parameter TRAIL_HALF_BITS, default 4: idle-low half-bits driven after the last data bit; legal range 0..255.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 preamble  input  32  frame field 1.
REQ-007 type_1, type_2  input  16 each  frame fields 2 and 3.
REQ-008 constant, thermostat_id  input  32 each  frame fields 4 and 5.
REQ-009 room_temp, set_temp  input  16 each  frame fields 6 and 7.
REQ-010 state  input  8  frame field 8.
REQ-011 tail_1, tail_2, tail_3  input  8 each  frame fields 9 to 11.
REQ-012 manchester_out  output  1  encoded line; idles low.
REQ-013 busy  output  1  high while a frame or its trailer is in progress.
REQ-014 done  output  1  one-cycle pulse at frame completion.
REQ-015 bit_strobe  output  1  one-cycle pulse at each mid-bit transition, for loopback checking.

Function
REQ-016 Frame SHALL be 192 bits, concatenated in order {preamble, type_1, type_2, constant, thermostat_id, room_temp, set_temp, state, tail_1, tail_2, tail_3}, sent MSB first (preamble[31] first, tail_3[0] last).
REQ-017 States SHALL be IDLE, SEND and TRAIL; reset enters IDLE.
REQ-018 IDLE: start=1 at edge k SHALL latch all field inputs into a 192-bit shift register, enter SEND and assert busy from cycle k+1.
REQ-019 Field inputs SHALL be ignored outside the accepting edge; mid-frame input changes SHALL NOT affect the frame on the line.
REQ-020 Encoding: bit 1 = low first half, high second half; bit 0 = high first half, low second half.
REQ-021 Each half-bit SHALL last exactly HALF_BIT_CYCLES cycles; the first half of bit 0 begins at cycle k+1.
REQ-022 bit_strobe SHALL pulse in the first cycle of each second half-bit (192 pulses per frame).
REQ-023 A 12-bit half-bit timer SHALL count 0..HALF_BIT_CYCLES-1 and wrap; an 8-bit bit counter SHALL count 0..191; the shift register SHALL shift left once per completed bit.
REQ-024 After bit 191 completes, the state SHALL go to TRAIL, with manchester_out low for TRAIL_HALF_BITS*HALF_BIT_CYCLES cycles (zero cycles if TRAIL_HALF_BITS=0).
REQ-025 At the end of TRAIL, the state SHALL return to IDLE, with done=1 and busy=0 in the first IDLE cycle.
REQ-026 Total cycles from the first busy cycle to the done cycle, exclusive, SHALL be (384+TRAIL_HALF_BITS)*HALF_BIT_CYCLES.
REQ-027 start SHALL be ignored while busy=1; no queuing.
REQ-028 start=1 in the done cycle SHALL be accepted, giving back-to-back frames separated only by the trailer.
REQ-029 manchester_out, busy, done and bit_strobe SHALL be registered outputs, glitch-free.

Reset
REQ-030 While reset=1, and immediately on assertion (asynchronous), outputs SHALL be: manchester_out=0, busy=0, done=0, bit_strobe=0; the state, counters and shift register SHALL clear to 0.
REQ-031 Reset mid-frame SHALL abort the frame with no done pulse; the first start after reset release SHALL send a complete fresh frame.

Verification (HALF_BIT_CYCLES=2, TRAIL_HALF_BITS=4 unless noted)
REQ-032 Loopback: preamble=32'hAAAAAAAA, thermostat_id=32'h12345678, room_temp=16'h00D2, set_temp=16'h00C8, state=8'h01, others 0 -> the serial decoder recovers identical fields, with 192 bit_strobe pulses.
REQ-033 Timing: start pulse at cycle 10 -> busy=1 at cycle 11; manchester_out for preamble[31]=1 reads 0,0,1,1 over cycles 11-14; done=1 at cycle 11+776=787.
REQ-034 All-zero frame -> line toggles high then low every bit; 192 falling mid-bit edges; 8 cycles low in TRAIL.
REQ-035 start held high continuously -> exactly one frame per 776+1 cycles, and start during busy does not restart the frame.
REQ-036 reset asserted asynchronously at bit 100 -> manchester_out=0 and busy=0 within the same cycle; no done pulse; the next start sends the full 192 bits.
REQ-037 TRAIL_HALF_BITS=0, HALF_BIT_CYCLES=1 -> done exactly 384 cycles after busy rises; input changes after acceptance do not alter the line.

Source files
------------

// File: rtl/bep_frame_encoder.sv
// Manchester encoder for a fixed 192-bit thermostat frame, MSB first, followed by an idle-low trailer.
// Bit 1 is sent low-then-high and bit 0 high-then-low; bit_strobe marks each mid-bit transition.
module bep_frame_encoder #(
    parameter int HALF_BIT_CYCLES = 250,
    parameter int TRAIL_HALF_BITS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] preamble,
    input  logic [15:0] type_1,
    input  logic [15:0] type_2,
    input  logic [31:0] constant,
    input  logic [31:0] thermostat_id,
    input  logic [15:0] room_temp,
    input  logic [15:0] set_temp,
    input  logic [7:0]  state,
    input  logic [7:0]  tail_1,
    input  logic [7:0]  tail_2,
    input  logic [7:0]  tail_3,
    output logic        manchester_out,
    output logic        busy,
    output logic        done,
    output logic        bit_strobe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        TRAIL = 2'd2
    } fsm_e;

    localparam logic [11:0] HB_LAST    = 12'(HALF_BIT_CYCLES - 1);
    localparam logic [7:0]  TRAIL_LAST = 8'(TRAIL_HALF_BITS - 1);
    localparam logic [7:0]  BIT_LAST   = 8'd191;

    fsm_e         fsm_q, fsm_d;
    logic [11:0]  timer_q, timer_d;
    logic         half_q, half_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   trail_cnt_q, trail_cnt_d;
    logic [191:0] shift_q, shift_d;
    logic         out_q, out_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         strobe_q, strobe_d;

    // Next-state logic: every output is computed here one cycle ahead and registered below.
    always_comb begin
        fsm_d       = fsm_q;
        timer_d     = timer_q;
        half_d      = half_q;
        bit_cnt_d   = bit_cnt_q;
        trail_cnt_d = trail_cnt_q;
        shift_d     = shift_q;
        out_d       = out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        strobe_d    = 1'b0;

        case (fsm_q)
            IDLE: begin
                out_d  = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    shift_d   = {preamble, type_1, type_2, constant, thermostat_id,
                                 room_temp, set_temp, state, tail_1, tail_2, tail_3};
                    fsm_d     = SEND;
                    busy_d    = 1'b1;
                    timer_d   = 12'd0;
                    half_d    = 1'b0;
                    bit_cnt_d = 8'd0;
                    out_d     = ~preamble[31];
                end else begin
                    timer_d     = 12'd0;
                    half_d      = 1'b0;
                    bit_cnt_d   = 8'd0;
                    trail_cnt_d = 8'd0;
                end
            end

            SEND: begin
                if (timer_q == HB_LAST) begin
                    timer_d = 12'd0;
                    if (!half_q) begin
                        half_d   = 1'b1;
                        out_d    = shift_q[191];
                        strobe_d = 1'b1;
                    end else begin
                        half_d  = 1'b0;
                        shift_d = {shift_q[190:0], 1'b0};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = 8'd0;
                            out_d     = 1'b0;
                            if (TRAIL_HALF_BITS == 0) begin
                                fsm_d  = IDLE;
                                busy_d = 1'b0;
                                done_d = 1'b1;
                            end else begin
                                fsm_d       = TRAIL;
                                trail_cnt_d = 8'd0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                            // First half of the next bit is the complement of that bit.
                            out_d     = ~shift_q[190];
                        end
                    end
                end else begin
                    timer_d = timer_q + 12'd1;
                end
            end

            TRAIL: begin
                out_d = 1'b0;
                if (timer_q == HB_LAST) begin
                    timer_d = 12'd0;
                    if (trail_cnt_q == TRAIL_LAST) begin
                        fsm_d       = IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        trail_cnt_d = 8'd0;
                    end else begin
                        trail_cnt_d = trail_cnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + 12'd1;
                end
            end

            default: begin
                fsm_d       = IDLE;
                timer_d     = 12'd0;
                half_d      = 1'b0;
                bit_cnt_d   = 8'd0;
                trail_cnt_d = 8'd0;
                out_d       = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q       <= IDLE;
            timer_q     <= 12'd0;
            half_q      <= 1'b0;
            bit_cnt_q   <= 8'd0;
            trail_cnt_q <= 8'd0;
            shift_q     <= 192'd0;
            out_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            timer_q     <= timer_d;
            half_q      <= half_d;
            bit_cnt_q   <= bit_cnt_d;
            trail_cnt_q <= trail_cnt_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            strobe_q    <= strobe_d;
        end
    end

    assign manchester_out = out_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign bit_strobe     = strobe_q;

endmodule
